// File: rtl/mac_rr_sched.sv
// Round-robin front end that shares one MAC between two requesters: it serialises
// one K-element job onto the MAC strobes, waits RES_LAT cycles, and returns the tagged result.
module mac_rr_sched #(
    parameter int K       = 4,
    parameter int RES_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [K*K-1:0]   req0_in,
    input  logic [K*K-1:0]   req0_w,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [K*K-1:0]   req1_in,
    input  logic [K*K-1:0]   req1_w,
    output logic [K-1:0]     mac_in,
    output logic [K-1:0]     mac_w,
    output logic             mac_strobe_in,
    output logic             mac_strobe_w,
    input  logic [2*K-1:0]   mac_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [2*K-1:0]   rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [K*K-1:0]   in_q, w_q;
    logic [K-1:0]     mac_in_q, mac_w_q;
    logic             strobe_q;
    logic             last_grant_q;
    logic             id_q;
    logic             rsp_id_q;
    logic [2*K-1:0]   rsp_data_q;
    logic             grant0, grant1, accept;
    logic [K*K-1:0]   sel_in, sel_w;
    logic             feed_more, wait_done;

    // Tie-break goes to whoever did not win last; only evaluated in IDLE.
    always_comb begin
        grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
        grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);
        accept = grant0 || grant1;
        sel_in = grant1 ? req1_in : req0_in;
        sel_w  = grant1 ? req1_w  : req0_w;
        feed_more = (state_q == FEED) && (cnt_q != 4'(K - 1));
        wait_done = (state_q == WAIT) && (cnt_q == 4'(RES_LAT - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: if (cnt_q == 4'(K - 1)) begin
                state_d = WAIT;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 4'd1;
            end
            WAIT: if (cnt_q == 4'(RES_LAT - 1)) begin
                state_d = RESP;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 4'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Element 0 is launched straight from the requester on the accept edge;
    // the rest shift out of the latched copy one per FEED cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q         <= '0;
            w_q          <= '0;
            mac_in_q     <= '0;
            mac_w_q      <= '0;
            strobe_q     <= 1'b0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            mac_in_q <= '0;
            mac_w_q  <= '0;
            strobe_q <= 1'b0;
            if (accept) begin
                in_q         <= sel_in >> K;
                w_q          <= sel_w >> K;
                mac_in_q     <= sel_in[K-1:0];
                mac_w_q      <= sel_w[K-1:0];
                strobe_q     <= 1'b1;
                last_grant_q <= grant1;
                id_q         <= grant1;
            end else if (feed_more) begin
                in_q     <= in_q >> K;
                w_q      <= w_q >> K;
                mac_in_q <= in_q[K-1:0];
                mac_w_q  <= w_q[K-1:0];
                strobe_q <= 1'b1;
            end
            if (wait_done) begin
                rsp_data_q <= mac_result;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign mac_in        = mac_in_q;
    assign mac_w         = mac_w_q;
    assign mac_strobe_in = strobe_q;
    assign mac_strobe_w  = strobe_q;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = rsp_id_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mac_rr_sched.sv
// Bench for mac_rr_sched: MAC model plus a per-cycle scoreboard of expected strobes and
// responses, a table of single-requester jobs, and hand sequences for arbitration and reset.
module tb_mac_rr_sched;
    localparam int K  = 4;
    localparam int RL = 3;
    localparam int LAT = K + RL + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [K*K-1:0] req0_in, req0_w, req1_in, req1_w;
    logic [K-1:0] mac_in, mac_w;
    logic mac_strobe_in, mac_strobe_w;
    logic [2*K-1:0] mac_result;
    logic rsp_valid, rsp_id, busy;
    logic [2*K-1:0] rsp_data;

    always #5 clk = ~clk;

    mac_rr_sched #(.K(K), .RES_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in), .req0_w(req0_w),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in), .req1_w(req1_w),
        .mac_in(mac_in), .mac_w(mac_w), .mac_strobe_in(mac_strobe_in), .mac_strobe_w(mac_strobe_w),
        .mac_result(mac_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    // MAC model: signed multiply-accumulate, restarting on the first strobe of a burst.
    logic [2*K-1:0] acc, prod;
    logic prev_stb;
    assign prod = {{K{mac_in[K-1]}}, mac_in} * {{K{mac_w[K-1]}}, mac_w};
    always @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            prev_stb <= 1'b0;
        end else begin
            prev_stb <= mac_strobe_in;
            if (mac_strobe_in) acc <= (prev_stb ? acc : '0) + prod;
        end
    end
    assign mac_result = acc;

    function automatic logic [2*K-1:0] dot(input logic [K*K-1:0] a, input logic [K*K-1:0] b);
        logic [2*K-1:0] s;
        logic [K-1:0] ae, be;
        s = '0;
        for (int e = 0; e < K; e++) begin
            ae = a[e*K +: K];
            be = b[e*K +: K];
            s = s + ({{K{ae[K-1]}}, ae} * {{K{be[K-1]}}, be});
        end
        return s;
    endfunction

    int nvec = 0, nmis = 0, cyc = 0, busy_end = 0, nrsp = 0, last_rsp_cyc = 0;
    logic lg = 1'b1;
    logic last_rsp_id;
    logic [2*K-1:0] last_rsp_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {int cyc; logic [K-1:0] a; logic [K-1:0] w;} feed_t;
    typedef struct {int cyc; logic id; logic [2*K-1:0] d;} rsp_t;
    feed_t fq[$];
    rsp_t  rq[$];
    int    acc_cyc[$];
    logic  acc_id[$];
    logic  rsp_ids[$];
    logic  m_idle, m_r0, m_r1, m_exp_v;
    logic [K*K-1:0] m_a, m_w;

    // Scoreboard: accepts push expected strobe cycles and responses; every cycle is checked.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            fq.delete();
            rq.delete();
            busy_end = cyc;
            lg = 1'b1;
        end else begin
            m_idle = cyc > busy_end;
            m_r0 = m_idle && req0_valid && (!req1_valid || lg);
            m_r1 = m_idle && req1_valid && (!req0_valid || !lg);
            chk("req0_ready", req0_ready, m_r0);
            chk("req1_ready", req1_ready, m_r1);
            chk("busy", busy, !m_idle);
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
                chk("feed", {mac_strobe_in, mac_strobe_w, mac_in, mac_w}, {2'b11, fq[0].a, fq[0].w});
                void'(fq.pop_front());
            end else begin
                chk("feed_idle", {mac_strobe_in, mac_strobe_w, mac_in, mac_w}, 0);
            end
            m_exp_v = rq.size() > 0 && rq[0].cyc == cyc;
            chk("rsp_valid", rsp_valid, m_exp_v);
            if (rsp_valid) begin
                nrsp++;
                last_rsp_cyc = cyc;
                last_rsp_id = rsp_id;
                last_rsp_data = rsp_data;
                rsp_ids.push_back(rsp_id);
            end
            if (m_exp_v) begin
                chk("rsp_id", rsp_id, rq[0].id);
                chk("rsp_data", rsp_data, rq[0].d);
                void'(rq.pop_front());
            end
            if (m_r0 || m_r1) begin
                m_a = m_r1 ? req1_in : req0_in;
                m_w = m_r1 ? req1_w : req0_w;
                for (int c = 0; c < K; c++)
                    fq.push_back('{cyc + 1 + c, m_a[c*K +: K], m_w[c*K +: K]});
                rq.push_back('{cyc + LAT, m_r1, dot(m_a, m_w)});
                busy_end = cyc + LAT;
                lg = m_r1;
                acc_cyc.push_back(cyc);
                acc_id.push_back(m_r1);
            end
        end
    end

    task automatic wait_acc(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (acc_cyc.size() >= n) break;
        end
        chk("accept_timeout", acc_cyc.size() >= n, 1);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (nrsp >= n) break;
        end
        chk("rsp_timeout", nrsp >= n, 1);
    endtask

    typedef struct {
        logic [K*K-1:0] i0, w0, i1, w1;
        logic v0, v1, id;
        logic [2*K-1:0] d;
    } vec_t;
    vec_t tbl[6];
    int base, rbase, t0;

    initial begin
        tbl[0] = '{16'h4321, 16'h1111, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h0A};
        tbl[1] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h2222, 1'b0, 1'b1, 1'b1, 8'hF8};
        tbl[2] = '{16'h7777, 16'h7777, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 8'hC4};
        tbl[3] = '{16'h0000, 16'h0000, 16'h8888, 16'h8888, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[4] = '{16'h8888, 16'h7777, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h20};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0F01, 16'h3456, 1'b0, 1'b1, 1'b1, 8'h02};
        req0_valid = 0; req1_valid = 0;
        req0_in = '0; req0_w = '0; req1_in = '0; req1_w = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_state", {busy, rsp_valid, rsp_id, rsp_data, mac_strobe_in}, 0);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            req0_in = tbl[i].i0; req0_w = tbl[i].w0; req0_valid = tbl[i].v0;
            req1_in = tbl[i].i1; req1_w = tbl[i].w1; req1_valid = tbl[i].v1;
            wait_acc(i + 1, 20);
            #1 req0_valid = 0; req1_valid = 0;
            wait_rsp(i + 1, 20);
            chk("tbl_id", last_rsp_id, tbl[i].id);
            chk("tbl_data", last_rsp_data, tbl[i].d);
            chk("tbl_lat", last_rsp_cyc - acc_cyc[acc_cyc.size()-1], LAT);
        end

        // Both requesters valid straight out of reset: strict alternation, 9-cycle period.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        base = acc_cyc.size(); rbase = nrsp;
        req0_in = 16'h1234; req0_w = 16'h1111; req1_in = 16'h2222; req1_w = 16'h1111;
        req0_valid = 1; req1_valid = 1;
        wait_acc(base + 4, 60);
        #1 req0_valid = 0; req1_valid = 0;
        wait_rsp(rbase + 4, 20);
        for (int j = 0; j < 4; j++) begin
            chk("alt_grant", acc_id[base+j], j % 2);
            chk("alt_rsp_id", rsp_ids[rbase+j], j % 2);
            if (j > 0) chk("alt_period", acc_cyc[base+j] - acc_cyc[base+j-1], 9);
        end

        // Reset in the second FEED cycle drops the job; req0 wins the next arbitration.
        base = acc_cyc.size(); rbase = nrsp;
        @(posedge clk); #1;
        req0_in = 16'h4321; req0_w = 16'h1111; req0_valid = 1;
        wait_acc(base + 1, 20);
        #1 req0_valid = 0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        req0_in = 16'h2222; req0_w = 16'h3333; req1_in = 16'h5555; req1_w = 16'h1111;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("rst_mid", {mac_strobe_in, mac_strobe_w, busy, rsp_valid}, 0);
        wait_acc(base + 2, 20);
        #1 req0_valid = 0; req1_valid = 0;
        chk("rst_first_grant", acc_id[acc_cyc.size()-1], 0);
        wait_rsp(rbase + 1, 20);
        chk("rst_rsp_data", last_rsp_data, 8'h18);
        chk("rst_rsp_id", last_rsp_id, 0);
        repeat (2) @(posedge clk);
        chk("rst_no_extra_rsp", nrsp - rbase, 1);

        // req1 arrives mid-job while req0 stays valid; req1 takes the first IDLE cycle.
        base = acc_cyc.size(); rbase = nrsp;
        @(posedge clk); #1;
        req0_in = 16'h1111; req0_w = 16'h5555; req0_valid = 1;
        wait_acc(base + 1, 20);
        t0 = acc_cyc[acc_cyc.size()-1];
        repeat (2) @(posedge clk);
        #1 req1_in = 16'h1111; req1_w = 16'h1111; req1_valid = 1;
        wait_acc(base + 2, 20);
        #1 req0_valid = 0; req1_valid = 0;
        chk("late_grant", acc_id[acc_cyc.size()-1], 1);
        chk("late_cycle", acc_cyc[acc_cyc.size()-1] - t0, 9);
        wait_rsp(rbase + 2, 30);
        chk("late_rsp_id", last_rsp_id, 1);
        chk("late_rsp_data", last_rsp_data, 8'h04);

        // Idle: nothing moves and the last response stays on rsp_data/rsp_id.
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_hold_data", rsp_data, 8'h04);
        chk("idle_hold_id", rsp_id, 1);
        chk("idle_quiet", {busy, rsp_valid, mac_strobe_in, mac_strobe_w}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout cyc=%0d got=running want=done", cyc);
        $fatal(1, "timeout");
    end
endmodule
